// File: rtl/dir_cache_pkg.sv
// Shared encodings for the directory-based MSI cache controller.
package dir_cache_pkg;

    typedef enum logic [1:0] {
        LINE_INVALID  = 2'b00,
        LINE_MODIFIED = 2'b01,
        LINE_SHARED   = 2'b10
    } line_state_e;

    typedef enum logic [1:0] {
        MSG_READ_MISS  = 2'b00,
        MSG_WRITE_MISS = 2'b01,
        MSG_INVALIDATE = 2'b10,
        MSG_WRITE_BACK = 2'b11
    } msg_type_e;

    typedef enum logic [1:0] {
        DIR_FETCH      = 2'b00,
        DIR_INVALIDATE = 2'b01,
        DIR_FETCH_INV  = 2'b10,
        DIR_REPLY      = 2'b11
    } dir_type_e;

    typedef enum logic [2:0] {
        CTRL_IDLE       = 3'd0,
        CTRL_SEND_WB    = 3'd1,
        CTRL_SEND_REQ   = 3'd2,
        CTRL_WAIT_REPLY = 3'd3,
        CTRL_RESPOND    = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/dir_cache_if.sv
// CPU, outgoing message, incoming directory and fetch-response buses of the cache controller.
// The slave modport is the controller; the master modport is the CPU/directory environment.
interface dir_cache_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              cpu_valid;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              msg_valid;
    logic [1:0]        msg_type;
    logic [ADDR_W-1:0] msg_addr;
    logic [DATA_W-1:0] msg_data;
    logic              msg_ready;

    logic              dir_valid;
    logic [1:0]        dir_type;
    logic [ADDR_W-1:0] dir_addr;
    logic [DATA_W-1:0] dir_data;
    logic              dir_ready;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_done, cpu_rdata,
        output msg_valid, msg_type, msg_addr, msg_data,
        input  msg_ready,
        input  dir_valid, dir_type, dir_addr, dir_data,
        output dir_ready,
        output wb_valid, wb_addr, wb_data
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_done, cpu_rdata,
        input  msg_valid, msg_type, msg_addr, msg_data,
        output msg_ready,
        output dir_valid, dir_type, dir_addr, dir_data,
        input  dir_ready,
        input  wb_valid, wb_addr, wb_data
    );

endinterface

// File: rtl/dir_cache_line_fsm.sv
// Combinational MSI decisions for one selected line: CPU hit/miss classification
// and the line's reaction to a directory request.
module dir_cache_line_fsm
    import dir_cache_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  line_state_e      line_st,
    input  logic [TAG_W-1:0] line_tag,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             cpu_we,
    input  dir_type_e        dir_type,
    output logic             cpu_hit,
    output logic             victim_wb,
    output msg_type_e        req_msg,
    output line_state_e      dir_next,
    output logic             dir_wb
);
    logic present;
    logic upgrade;

    always_comb begin
        present   = (line_st != LINE_INVALID) && (line_tag == req_tag);
        cpu_hit   = present && ((line_st == LINE_MODIFIED) || !cpu_we);
        upgrade   = present && (line_st == LINE_SHARED) && cpu_we;
        // A differing tag on a dirty line means the victim must be written back first.
        victim_wb = !present && (line_st == LINE_MODIFIED);

        if (upgrade) begin
            req_msg = MSG_INVALIDATE;
        end else if (cpu_we) begin
            req_msg = MSG_WRITE_MISS;
        end else begin
            req_msg = MSG_READ_MISS;
        end

        dir_next = line_st;
        dir_wb   = 1'b0;
        if (present) begin
            case (dir_type)
                DIR_FETCH: begin
                    if (line_st == LINE_MODIFIED) begin
                        dir_next = LINE_SHARED;
                        dir_wb   = 1'b1;
                    end
                end
                DIR_FETCH_INV: begin
                    if (line_st == LINE_MODIFIED) begin
                        dir_next = LINE_INVALID;
                        dir_wb   = 1'b1;
                    end
                end
                DIR_INVALIDATE: dir_next = LINE_INVALID;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dir_cache_controller.sv
// Direct-mapped MSI cache controller talking to a directory; hits finish in one cycle,
// misses and upgrades go through the message/reply handshake.
module dir_cache_controller
    import dir_cache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    dir_cache_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int ADDR_W = TAG_W + IDX_W;

    line_state_e       line_st_q   [NUM_LINES];
    logic [TAG_W-1:0]  line_tag_q  [NUM_LINES];
    logic [DATA_W-1:0] line_data_q [NUM_LINES];

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic              req_we_q;
    logic [DATA_W-1:0] req_wdata_q;
    msg_type_e         req_kind_q;
    logic              retry_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;

    dir_type_e         dir_type;
    logic [IDX_W-1:0]  cpu_idx, dir_idx, sel_idx, req_idx;
    logic [TAG_W-1:0]  cpu_tag, dir_tag, sel_tag, req_tag;
    logic              cpu_ready, dir_ready;
    logic              cpu_acc, dir_acc, reply_acc, retry_set;
    logic              cpu_hit, victim_wb, dir_wb;
    msg_type_e         miss_msg;
    line_state_e       dir_next;

    assign dir_type = dir_type_e'(bus.dir_type);
    assign cpu_idx  = bus.cpu_addr[IDX_W-1:0];
    assign cpu_tag  = bus.cpu_addr[ADDR_W-1:IDX_W];
    assign dir_idx  = bus.dir_addr[IDX_W-1:0];
    assign dir_tag  = bus.dir_addr[ADDR_W-1:IDX_W];
    assign req_idx  = req_addr_q[IDX_W-1:0];
    assign req_tag  = req_addr_q[ADDR_W-1:IDX_W];

    // Ready outputs are gated by rst_n so they drop the moment reset asserts.
    assign cpu_ready = rst_n && (state_q == CTRL_IDLE) && !bus.dir_valid;
    assign dir_ready = rst_n && ((state_q == CTRL_IDLE) || (state_q == CTRL_WAIT_REPLY));
    assign cpu_acc   = bus.cpu_valid && cpu_ready;
    assign dir_acc   = bus.dir_valid && dir_ready;
    assign reply_acc = dir_acc && (dir_type == DIR_REPLY) && (state_q == CTRL_WAIT_REPLY);
    assign retry_set = dir_acc && (state_q == CTRL_WAIT_REPLY) && (dir_type == DIR_INVALIDATE)
                       && (bus.dir_addr == req_addr_q) && (req_kind_q == MSG_INVALIDATE);

    // CPU and directory are never accepted together, so one decoder serves both.
    assign sel_idx = bus.dir_valid ? dir_idx : cpu_idx;
    assign sel_tag = bus.dir_valid ? dir_tag : cpu_tag;

    dir_cache_line_fsm #(.TAG_W(TAG_W)) u_line_fsm (
        .line_st   (line_st_q[sel_idx]),
        .line_tag  (line_tag_q[sel_idx]),
        .req_tag   (sel_tag),
        .cpu_we    (bus.cpu_we),
        .dir_type  (dir_type),
        .cpu_hit   (cpu_hit),
        .victim_wb (victim_wb),
        .req_msg   (miss_msg),
        .dir_next  (dir_next),
        .dir_wb    (dir_wb)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            CTRL_IDLE: begin
                if (cpu_acc) begin
                    if (cpu_hit) begin
                        state_d = CTRL_RESPOND;
                    end else if (victim_wb) begin
                        state_d = CTRL_SEND_WB;
                    end else begin
                        state_d = CTRL_SEND_REQ;
                    end
                end
            end
            CTRL_SEND_WB:    if (bus.msg_ready) state_d = CTRL_SEND_REQ;
            CTRL_SEND_REQ:   if (bus.msg_ready) state_d = CTRL_WAIT_REPLY;
            CTRL_WAIT_REPLY: if (reply_acc) state_d = retry_q ? CTRL_SEND_REQ : CTRL_RESPOND;
            CTRL_RESPOND:    state_d = CTRL_IDLE;
            default:         state_d = CTRL_IDLE;
        endcase
    end

    always_comb begin
        bus.msg_valid = 1'b0;
        bus.msg_type  = '0;
        bus.msg_addr  = '0;
        bus.msg_data  = '0;
        case (state_q)
            CTRL_SEND_WB: begin
                bus.msg_valid = 1'b1;
                bus.msg_type  = MSG_WRITE_BACK;
                bus.msg_addr  = {line_tag_q[req_idx], req_idx};
                bus.msg_data  = line_data_q[req_idx];
            end
            CTRL_SEND_REQ: begin
                bus.msg_valid = 1'b1;
                bus.msg_type  = req_kind_q;
                bus.msg_addr  = req_addr_q;
                bus.msg_data  = req_we_q ? req_wdata_q : '0;
            end
            default: ;
        endcase
    end

    assign bus.cpu_ready = cpu_ready;
    assign bus.dir_ready = dir_ready;
    assign bus.cpu_done  = (state_q == CTRL_RESPOND);
    assign bus.cpu_rdata = resp_data_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CTRL_IDLE;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            req_kind_q  <= MSG_READ_MISS;
            retry_q     <= 1'b0;
            resp_data_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= 1'b0;
            if (cpu_acc) begin
                req_addr_q  <= bus.cpu_addr;
                req_we_q    <= bus.cpu_we;
                req_wdata_q <= bus.cpu_wdata;
                req_kind_q  <= miss_msg;
                if (cpu_hit) begin
                    resp_data_q <= bus.cpu_we ? bus.cpu_wdata : line_data_q[cpu_idx];
                end
            end
            if (dir_acc && dir_wb) begin
                wb_valid_q <= 1'b1;
                wb_addr_q  <= bus.dir_addr;
                wb_data_q  <= line_data_q[dir_idx];
            end
            if (retry_set) begin
                retry_q <= 1'b1;
            end
            // A lost upgrade comes back as a full write miss instead of completing.
            if (reply_acc) begin
                if (retry_q) begin
                    retry_q    <= 1'b0;
                    req_kind_q <= MSG_WRITE_MISS;
                end else begin
                    resp_data_q <= req_we_q ? req_wdata_q : bus.dir_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                line_st_q[i]   <= LINE_INVALID;
                line_tag_q[i]  <= '0;
                line_data_q[i] <= '0;
            end
        end else begin
            if (dir_acc && (dir_type != DIR_REPLY)) begin
                line_st_q[dir_idx] <= dir_next;
            end
            if (cpu_acc && cpu_hit && bus.cpu_we) begin
                line_data_q[cpu_idx] <= bus.cpu_wdata;
            end
            // Once written back the victim no longer owns data the directory could fetch.
            if ((state_q == CTRL_SEND_WB) && bus.msg_ready) begin
                line_st_q[req_idx] <= LINE_INVALID;
            end
            if (reply_acc && !retry_q) begin
                line_st_q[req_idx]   <= req_we_q ? LINE_MODIFIED : LINE_SHARED;
                line_tag_q[req_idx]  <= req_tag;
                line_data_q[req_idx] <= req_we_q ? req_wdata_q : bus.dir_data;
            end
        end
    end

endmodule

// File: tb/tb_dir_cache_controller.sv
// Directed bench for dir_cache_controller: misses, hits, write-back, directory fetch/invalidate,
// upgrade retry and mid-transaction reset, using the default 4-line, 4-bit-tag geometry.
module tb_dir_cache_controller;

    localparam logic [1:0] M_RM = 2'b00, M_WM = 2'b01, M_INV = 2'b10, M_WB = 2'b11;
    localparam logic [1:0] D_FETCH = 2'b00, D_INV = 2'b01, D_FETCH_INV = 2'b10, D_REPLY = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    dir_cache_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    dir_cache_controller #(.NUM_LINES(4), .TAG_W(4), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request, confirm it is accepted, then scramble the inputs.
    task automatic cpu_req(input string tag, input logic we, input logic [5:0] addr,
                           input logic [7:0] wdata);
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        #1 check({tag, "_cpu_ready"}, bus.cpu_ready, 1);
        cyc();
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = ~we;
        bus.cpu_addr  = 6'h3E;
        bus.cpu_wdata = 8'hEE;
    endtask

    task automatic expect_msg(input string tag, input logic [1:0] mtype, input logic [5:0] addr,
                              input logic chk_data, input logic [7:0] data);
        #1;
        check({tag, "_msg_valid"}, bus.msg_valid, 1);
        check({tag, "_msg_type"}, bus.msg_type, mtype);
        check({tag, "_msg_addr"}, bus.msg_addr, addr);
        if (chk_data) check({tag, "_msg_data"}, bus.msg_data, data);
        bus.msg_ready = 1'b1;
        cyc();
        bus.msg_ready = 1'b0;
    endtask

    task automatic dir_op(input string tag, input logic [1:0] dtype, input logic [5:0] addr,
                          input logic [7:0] data);
        bus.dir_valid = 1'b1;
        bus.dir_type  = dtype;
        bus.dir_addr  = addr;
        bus.dir_data  = data;
        #1 check({tag, "_dir_ready"}, bus.dir_ready, 1);
        cyc();
        bus.dir_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic chk_rdata, input logic [7:0] rdata);
        #1;
        check({tag, "_done"}, bus.cpu_done, 1);
        if (chk_rdata) check({tag, "_rdata"}, bus.cpu_rdata, rdata);
        cyc();
        #1 check({tag, "_done_pulse"}, bus.cpu_done, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.msg_ready = 1'b0;
        bus.dir_valid = 1'b0;
        bus.dir_type  = '0;
        bus.dir_addr  = '0;
        bus.dir_data  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_ready", bus.cpu_ready, 0);
        check("rst_dir_ready", bus.dir_ready, 0);
        check("rst_msg_valid", bus.msg_valid, 0);
        check("rst_cpu_done", bus.cpu_done, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_outputs", {bus.msg_type, bus.msg_addr, bus.msg_data, bus.cpu_rdata,
                              bus.wb_addr, bus.wb_data}, 0);
        rst_n = 1'b1;
        #1;
        check("rel_cpu_ready", bus.cpu_ready, 1);
        check("rel_dir_ready", bus.dir_ready, 1);
        cyc();

        // Cold read miss, then a read hit on the now-shared line.
        cpu_req("rm05", 1'b0, 6'h05, 8'h00);
        expect_msg("rm05", M_RM, 6'h05, 1'b0, 8'h00);
        reply("rm05", 8'hA5);
        expect_done("rm05", 1'b1, 8'hA5);
        cpu_req("rh05", 1'b0, 6'h05, 8'h00);
        #1 check("rh05_no_msg", bus.msg_valid, 0);
        expect_done("rh05", 1'b1, 8'hA5);

        // Write on a shared line is an upgrade.
        cpu_req("up05", 1'b1, 6'h05, 8'h3C);
        expect_msg("up05", M_INV, 6'h05, 1'b0, 8'h00);
        reply("up05", 8'h77);
        expect_done("up05", 1'b0, 8'h00);
        cpu_req("rh05b", 1'b0, 6'h05, 8'h00);
        expect_done("rh05b", 1'b1, 8'h3C);

        // Conflict miss with a dirty victim.
        cpu_req("rm09", 1'b0, 6'h09, 8'h00);
        expect_msg("wb05", M_WB, 6'h05, 1'b1, 8'h3C);
        expect_msg("rm09", M_RM, 6'h09, 1'b0, 8'h00);
        reply("rm09", 8'h5A);
        expect_done("rm09", 1'b1, 8'h5A);

        // Shared victim is dropped: write miss goes straight out.
        cpu_req("wm05", 1'b1, 6'h05, 8'h3C);
        expect_msg("wm05", M_WM, 6'h05, 1'b1, 8'h3C);
        reply("wm05", 8'h00);
        expect_done("wm05", 1'b0, 8'h00);

        // Write hits on a modified line.
        cpu_req("wh05", 1'b1, 6'h05, 8'h11);
        #1 check("wh05_no_msg", bus.msg_valid, 0);
        expect_done("wh05", 1'b0, 8'h00);
        cpu_req("rh05c", 1'b0, 6'h05, 8'h00);
        expect_done("rh05c", 1'b1, 8'h11);
        cpu_req("wh05b", 1'b1, 6'h05, 8'h3C);
        expect_done("wh05b", 1'b0, 8'h00);

        // Directory FETCH_INV collides with a CPU request; the directory wins.
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 6'h05;
        bus.dir_valid = 1'b1;
        bus.dir_type  = D_FETCH_INV;
        bus.dir_addr  = 6'h05;
        #1;
        check("fi_cpu_ready", bus.cpu_ready, 0);
        check("fi_dir_ready", bus.dir_ready, 1);
        cyc();
        bus.dir_valid = 1'b0;
        #1;
        check("fi_wb_valid", bus.wb_valid, 1);
        check("fi_wb_addr", bus.wb_addr, 6'h05);
        check("fi_wb_data", bus.wb_data, 8'h3C);
        check("fi_cpu_ready2", bus.cpu_ready, 1);
        cyc();
        bus.cpu_valid = 1'b0;
        #1 check("fi_wb_pulse", bus.wb_valid, 0);
        expect_msg("fi_rm05", M_RM, 6'h05, 1'b0, 8'h00);
        reply("fi_rm05", 8'hC3);
        expect_done("fi_rm05", 1'b1, 8'hC3);

        // Upgrade loses the line while waiting and is reissued as a write miss.
        cpu_req("rt05", 1'b1, 6'h05, 8'h3C);
        expect_msg("rt05", M_INV, 6'h05, 1'b0, 8'h00);
        dir_op("rt05_inv", D_INV, 6'h05, 8'h00);
        reply("rt05_r1", 8'h00);
        #1 check("rt05_no_done", bus.cpu_done, 0);
        expect_msg("rt05_wm", M_WM, 6'h05, 1'b1, 8'h3C);
        reply("rt05_r2", 8'h00);
        expect_done("rt05", 1'b0, 8'h00);
        cpu_req("rt05_rd", 1'b0, 6'h05, 8'h00);
        expect_done("rt05_rd", 1'b1, 8'h3C);

        // FETCH downgrades a modified line to shared.
        dir_op("fe05", D_FETCH, 6'h05, 8'h00);
        #1;
        check("fe05_wb_valid", bus.wb_valid, 1);
        check("fe05_wb_addr", bus.wb_addr, 6'h05);
        check("fe05_wb_data", bus.wb_data, 8'h3C);
        cpu_req("fe05_rd", 1'b0, 6'h05, 8'h00);
        expect_done("fe05_rd", 1'b1, 8'h3C);

        // Held message must stay stable; then reset lands while waiting for the reply.
        cpu_req("hold", 1'b1, 6'h05, 8'h77);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_valid", bus.msg_valid, 1);
            check("hold_type", bus.msg_type, M_INV);
            check("hold_addr", bus.msg_addr, 6'h05);
            cyc();
        end
        expect_msg("hold", M_INV, 6'h05, 1'b0, 8'h00);
        #1 check("hold_wait_dir_ready", bus.dir_ready, 1);
        rst_n         = 1'b0;
        bus.dir_valid = 1'b1;
        bus.dir_type  = D_REPLY;
        bus.dir_data  = 8'h99;
        #1;
        check("mr_cpu_ready", bus.cpu_ready, 0);
        check("mr_dir_ready", bus.dir_ready, 0);
        check("mr_msg_valid", bus.msg_valid, 0);
        check("mr_cpu_done", bus.cpu_done, 0);
        check("mr_outputs", {bus.msg_type, bus.msg_addr, bus.msg_data, bus.cpu_rdata,
                             bus.wb_valid, bus.wb_addr, bus.wb_data}, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("mr_rel_done", bus.cpu_done, 0);
        check("mr_rel_cpu_ready", bus.cpu_ready, 0);
        check("mr_rel_dir_ready", bus.dir_ready, 1);
        cyc();
        bus.dir_valid = 1'b0;
        #1;
        check("mr_idle_reply_done", bus.cpu_done, 0);
        check("mr_cpu_ready_up", bus.cpu_ready, 1);
        cpu_req("post_rm05", 1'b0, 6'h05, 8'h00);
        expect_msg("post_rm05", M_RM, 6'h05, 1'b0, 8'h00);
        reply("post_rm05", 8'h42);
        expect_done("post_rm05", 1'b1, 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic reply(input string tag, input logic [7:0] data);
        dir_op({tag, "_reply"}, D_REPLY, 6'h00, data);
    endtask

endmodule

// File: doc/dir_cache_controller.md
DIR_CACHE_CONTROLLER -- requirements
Module: dir_cache_controller

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4: direct-mapped lines, power of two >= 2; IDX_W = clog2(NUM_LINES).
REQ-002 SHALL have parameter TAG_W, default 4: tag bits; ADDR_W = TAG_W + IDX_W, index = addr[IDX_W-1:0].
REQ-003 SHALL have parameter DATA_W, default 8: line data width.
REQ-004 SHALL use one clock and an asynchronous active-low reset, exactly as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have CPU ports:
- cpu_valid  in  1  request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W.
- cpu_wdata  in  DATA_W.
- cpu_ready  out  1  request accepted when cpu_valid&cpu_ready.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  valid with cpu_done.
REQ-006 SHALL have outgoing message ports:
- msg_valid  out  1.
- msg_type  out  2  00 READ_MISS, 01 WRITE_MISS, 10 INVALIDATE, 11 WRITE_BACK.
- msg_addr  out  ADDR_W.
- msg_data  out  DATA_W.
- msg_ready  in  1.
REQ-007 SHALL have incoming directory ports:
- dir_valid  in  1.
- dir_type  in  2  00 FETCH, 01 INVALIDATE, 10 FETCH_INV, 11 REPLY.
- dir_addr  in  ADDR_W.
- dir_data  in  DATA_W.
- dir_ready  out  1.
REQ-008 SHALL have fetch-response ports:
- wb_valid  out  1.
- wb_addr  out  ADDR_W.
- wb_data  out  DATA_W.
No backpressure on these ports.

Function
REQ-009 SHALL keep per line a 2-bit state INVALID=00, MODIFIED=01, SHARED=10, plus tag and data registers.
REQ-010 SHALL implement controller states IDLE, SEND_WB, SEND_REQ, WAIT_REPLY, RESPOND.
REQ-011 SHALL assert cpu_ready only in IDLE with dir_valid low; a simultaneous dir_valid wins, and the CPU waits.
REQ-012 Hit (tag match, line not INVALID; a write hit requires MODIFIED) SHALL go IDLE->RESPOND; cpu_done is asserted the cycle after acceptance, and a write updates data that same edge.
REQ-013 Read or write miss with a MODIFIED victim SHALL go to SEND_WB (WRITE_BACK, victim address and data), then SEND_REQ. Any other victim is dropped silently and goes directly to SEND_REQ.
REQ-014 SEND_REQ SHALL drive READ_MISS (read), WRITE_MISS (write miss) or INVALIDATE (write hit on SHARED) and hold msg_* stable until msg_valid&msg_ready, then enter WAIT_REPLY.
REQ-015 On REPLY in WAIT_REPLY: a read miss SHALL install dir_data as SHARED; a write miss or upgrade SHALL install cpu_wdata as MODIFIED. The controller then enters RESPOND, and cpu_done follows next cycle.
REQ-016 SHALL assert dir_ready in IDLE and WAIT_REPLY only. A REPLY arriving in IDLE is accepted and ignored.
REQ-017 Directory requests to a line that is not INVALID with matching tag SHALL behave as follows (all others are accepted with no effect):
- FETCH on MODIFIED: MODIFIED->SHARED.
- FETCH_INV on MODIFIED: ->INVALID.
- INVALIDATE on SHARED or MODIFIED: ->INVALID.
REQ-018 Every FETCH or FETCH_INV hitting a MODIFIED line SHALL pulse wb_valid for one cycle, the cycle after acceptance, with that line's address and pre-transition data.
REQ-019 An INVALIDATE hitting the line of a pending upgrade during WAIT_REPLY SHALL set a retry flag. On the following REPLY the controller returns to SEND_REQ issuing WRITE_MISS instead of completing.
REQ-020 cpu_wdata and cpu_addr SHALL be latched at acceptance; later changes on those inputs have no effect.

Reset
REQ-021 rst_n low SHALL immediately force:
- every line INVALID, with tags and data 0.
- controller state IDLE; retry flag 0.
- cpu_ready, cpu_done, msg_valid, dir_ready and wb_valid 0.
- all data, address and type outputs 0.
REQ-022 Reset mid-transaction SHALL abandon it without emitting cpu_done. After release, cpu_ready rises on the first cycle with dir_valid low.

Structure
REQ-023 Package dir_cache_pkg SHALL hold the line-state, msg_type, dir_type and controller-state encodings.
REQ-024 Per-line MSI next-state and send decisions SHALL live in sub-module dir_cache_line_fsm (combinational), with one instance per line or one shared instance selected by index.

Verification
REQ-025 Read 0x05 from reset -> READ_MISS addr 0x05; REPLY data 0xA5 -> cpu_done with rdata 0xA5; line 1 SHARED.
REQ-026 Write 0x05=0x3C on SHARED line -> INVALIDATE msg; REPLY -> line MODIFIED, data 0x3C, cpu_done.
REQ-027 Line 1 MODIFIED tag 0x1 data 0x3C, read 0x09 (tag 0x2) -> WRITE_BACK 0x05/0x3C, then READ_MISS 0x09.
REQ-028 FETCH_INV 0x05 with line MODIFIED, same cycle as cpu_valid -> cpu_ready 0; next cycle wb_valid with 0x05/0x3C; line INVALID.
REQ-029 Upgrade pending on 0x05, INVALIDATE 0x05 in WAIT_REPLY, then REPLY -> WRITE_MISS 0x05 reissued; second REPLY -> MODIFIED, cpu_done.
REQ-030 msg_ready held low 5 cycles, rst_n pulsed in WAIT_REPLY -> msg_* stable while held, outputs 0 at reset, no cpu_done.
